// File: rtl/trigb_mc_pkg.sv
// Shared defaults, FSM encoding and width helper for the predictor trigger block.
package trigb_mc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCOEF = 8;
  localparam int DEF_NCH   = 32;

  typedef enum logic {
    TRG_IDLE  = 1'b0,
    TRG_BURST = 1'b1
  } trg_state_t;

  // Index/channel fields stay at least one bit wide even for a single entry.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trigb_mc_if.sv
// Coefficient stream interface: input words from the update stage, output words towards RAM write-back.
interface trigb_mc_if
  import trigb_mc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCOEF = DEF_NCOEF,
  parameter int NCH   = DEF_NCH
);
  localparam int CHW  = clog2_min1(NCH);
  localparam int IDXW = clog2_min1(NCOEF);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic [CHW-1:0]          in_ch;
  logic                    TR;
  logic signed [WIDTH-1:0] AnP;
  logic                    out_valid;
  logic                    out_ready;
  logic [CHW-1:0]          out_ch;
  logic [IDXW-1:0]         out_idx;
  logic                    out_last;
  logic signed [WIDTH-1:0] AnR;

  modport master (
    output in_valid, in_first, in_ch, TR, AnP, out_ready,
    input  in_ready, out_valid, out_ch, out_idx, out_last, AnR
  );

  modport slave (
    input  in_valid, in_first, in_ch, TR, AnP, out_ready,
    output in_ready, out_valid, out_ch, out_idx, out_last, AnR
  );

endinterface

// File: rtl/trigb_outreg.sv
// Single output register with valid/ready hold and combinational upstream ready.
module trigb_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic         vld,
  output logic [W-1:0] q,
  output logic         ready
);

  assign ready = !vld || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (out_ready) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/trigb_mc.sv
// Multi-channel predictor trigger: zeroes whole coefficient bursts whose header carried TR,
// with burst framing checks and per-channel trigger status.
module trigb_mc
  import trigb_mc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCOEF = DEF_NCOEF,
  parameter int NCH   = DEF_NCH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scan_in0,
  input  logic           scan_in1,
  input  logic           scan_in2,
  input  logic           scan_in3,
  input  logic           scan_in4,
  input  logic           scan_enable,
  input  logic           test_mode,
  output logic           scan_out0,
  output logic           scan_out1,
  output logic           scan_out2,
  output logic           scan_out3,
  output logic           scan_out4,
  trigb_mc_if.slave      bus,
  output logic [NCH-1:0] tr_flags,
  output logic           err_seq,
  input  logic           err_clr
);

  localparam int CHW  = clog2_min1(NCH);
  localparam int IDXW = clog2_min1(NCOEF);
  localparam int OW   = WIDTH + CHW + IDXW + 1;

  function automatic logic signed [WIDTH-1:0] gate_coef(input logic trig,
                                                        input logic signed [WIDTH-1:0] coef);
    return trig ? '0 : coef;
  endfunction

  trg_state_t      state, state_n;
  logic [IDXW-1:0] idx, idx_n, e_idx;
  logic [CHW-1:0]  ch_l, e_ch;
  logic            trl, e_trl;
  logic            emit, err_set, accept, in_ready, ch_ok, vld_p1;
  logic [OW-1:0]   word_p0, word_p1;
  logic            unused_scan;

  assign scan_out0   = 1'b0;
  assign scan_out1   = 1'b0;
  assign scan_out2   = 1'b0;
  assign scan_out3   = 1'b0;
  assign scan_out4   = 1'b0;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;
  assign ch_ok        = 32'(bus.in_ch) < NCH;

  // A header always restarts framing, even if it cuts a burst short.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    e_idx   = idx + IDXW'(1);
    e_ch    = ch_l;
    e_trl   = trl;
    emit    = 1'b0;
    err_set = 1'b0;
    if (accept) begin
      if (bus.in_first) begin
        emit    = 1'b1;
        e_ch    = bus.in_ch;
        e_trl   = bus.TR;
        e_idx   = '0;
        idx_n   = '0;
        state_n = (NCOEF == 1) ? TRG_IDLE : TRG_BURST;
        err_set = (state == TRG_BURST) || !ch_ok;
      end else if (state == TRG_BURST) begin
        emit  = 1'b1;
        idx_n = e_idx;
        if (e_idx == IDXW'(NCOEF - 1)) state_n = TRG_IDLE;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  assign word_p0 = {e_ch, e_idx, (e_idx == IDXW'(NCOEF - 1)), gate_coef(e_trl, bus.AnP)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= TRG_IDLE;
      idx   <= '0;
      ch_l  <= '0;
      trl   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      ch_l  <= e_ch;
      trl   <= e_trl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_flags <= '0;
      err_seq  <= 1'b0;
    end else begin
      if (accept && bus.in_first && ch_ok) tr_flags[bus.in_ch] <= bus.TR;
      if (err_set)      err_seq <= 1'b1;
      else if (err_clr) err_seq <= 1'b0;
    end
  end

  // ---- stage p1: registered output word ----
  trigb_outreg #(.W(OW)) u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (emit),
    .d         (word_p0),
    .out_ready (bus.out_ready),
    .vld       (vld_p1),
    .q         (word_p1),
    .ready     (in_ready)
  );

  assign bus.out_valid = vld_p1;
  assign {bus.out_ch, bus.out_idx, bus.out_last, bus.AnR} = word_p1;

endmodule
